// File: rtl/fetch_controller.sv
// IF-stage fetch sequencer: owns the fetch PC, issues word reads, buffers results, hands them to ID.
// Latency: response earliest one cycle after accept; a pushed word appears on if_* the next cycle.
// Backpressure: issue stalls when the queue is full or a read is in flight; if_ready=0 freezes the head.
module fetch_controller #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2,
  parameter int          MEM_BYTES   = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  // Queue pointer and occupancy widths; a single-entry queue still needs a 1-bit pointer.
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  localparam logic [31:0]   ADDR_MASK = 32'(MEM_BYTES - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(QUEUE_DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(QUEUE_DEPTH - 1);

  // Fetch sequencer states: free to issue, waiting for our data, waiting for data to throw away.
  localparam logic [1:0] S_ISSUE = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;

  logic [1:0]    state;
  logic [31:0]   pc;
  logic [31:0]   req_pc;

  logic [31:0]   q_pc  [QUEUE_DEPTH];
  logic [31:0]   q_ins [QUEUE_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [PW-1:0] rd_ptr_nxt;
  logic [PW-1:0] wr_ptr_nxt;
  logic [CW-1:0] count_nxt;
  logic [CW-1:0] count_after_pop;
  logic          head_vld_nxt;
  logic [31:0]   head_pc_nxt;
  logic [31:0]   head_ins_nxt;

  logic          accept;
  logic          push;
  logic          pop;
  logic [31:0]   pc_seq;
  logic [31:0]   pc_branch;

  // Circular pointer advance that works for non-power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // Issue only from S_ISSUE with room for the reply; a branch this cycle suppresses the request
  // because the PC it would use is already stale.
  assign imem_req  = !rst && (state == S_ISSUE) && (count < DEPTH_C) && !branch_taken;
  assign imem_addr = pc;
  assign accept    = imem_req && imem_ready;

  // Only a response we are waiting for, and that no branch is overtaking, enters the queue.
  assign push = (state == S_WAIT) && imem_rvalid && !branch_taken;
  assign pop  = if_valid && if_ready;

  // Sequential and redirect PCs, both folded into the instruction memory window.
  assign pc_seq    = (pc + 32'd4) & ADDR_MASK;
  assign pc_branch = branch_addr & ~32'd3 & ADDR_MASK;

  // Next queue occupancy/pointers and the entry that will sit at the head after this edge.
  always_comb begin
    rd_ptr_nxt      = rd_ptr;
    wr_ptr_nxt      = wr_ptr;
    count_nxt       = count;
    count_after_pop = pop ? (count - CW'(1)) : count;
    head_pc_nxt     = q_pc[rd_ptr];
    head_ins_nxt    = q_ins[rd_ptr];

    if (branch_taken) begin
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (pop) begin
        rd_ptr_nxt = ptr_inc(rd_ptr);
      end
      if (push) begin
        wr_ptr_nxt = ptr_inc(wr_ptr);
      end
      count_nxt = count_after_pop + (push ? CW'(1) : CW'(0));
    end

    // A push into a queue that is empty after the pop becomes the head directly;
    // otherwise the head is whatever the read pointer lands on.
    if (push && (count_after_pop == '0)) begin
      head_pc_nxt  = req_pc;
      head_ins_nxt = imem_rdata;
    end else begin
      head_pc_nxt  = q_pc[rd_ptr_nxt];
      head_ins_nxt = q_ins[rd_ptr_nxt];
    end

    head_vld_nxt = (count_nxt != '0);
  end

  // Fetch PC and request/response sequencing; a branch overrides everything but reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_ISSUE;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else if (branch_taken) begin
      pc <= pc_branch;
      case (state)
        S_WAIT, S_DROP: state <= imem_rvalid ? S_ISSUE : S_DROP;
        default:        state <= S_ISSUE;
      endcase
    end else begin
      case (state)
        S_ISSUE: begin
          if (accept) begin
            req_pc <= pc;
            pc     <= pc_seq;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state <= S_ISSUE;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            state <= S_ISSUE;
          end
        end
        default: state <= S_ISSUE;
      endcase
    end
  end

  // Queue bookkeeping; a flush only needs the pointers and count cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr_nxt;
      count  <= count_nxt;
    end
  end

  // Queue storage; contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]  <= req_pc;
      q_ins[wr_ptr] <= imem_rdata;
    end
  end

  // Registered head view for ID; the data fields hold their last value while the queue is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid       <= 1'b0;
      if_instruction <= '0;
      if_pc          <= '0;
      if_pc_plus4    <= '0;
    end else begin
      if_valid <= head_vld_nxt;
      if (head_vld_nxt) begin
        if_instruction <= head_ins_nxt;
        if_pc          <= head_pc_nxt;
        if_pc_plus4    <= head_pc_nxt + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios pinned with literal values, then random traffic.
// A queue-based reference model is compared against every DUT output on every cycle.
// The memory responder delays replies and injects stray rvalids while nothing is outstanding.
module tb_fetch_controller;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          QD       = 2;
  localparam int          MB       = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  fetch_controller #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(QD), .MEM_BYTES(MB)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .if_ready(if_ready), .if_valid(if_valid), .if_instruction(if_instruction),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [MB];

  // Stimulus control
  bit          rnd    = 1'b0;
  bit          chk_on = 1'b0;
  logic        d_rst, d_ready, d_if_ready, d_br;
  logic [31:0] d_baddr;
  int          d_delay;

  // Memory responder
  bit          rsp_pending = 1'b0;
  int          rsp_delay   = 0;
  logic [31:0] rsp_addr    = '0;

  // Observed handshakes
  logic [31:0] acc_log [$];
  logic [31:0] pop_log [$];

  // Reference model
  logic [31:0] m_pc, m_req_pc;
  logic [63:0] m_q [$];
  bit          m_out, m_drop, m_vld;
  logic [31:0] m_ipc, m_ins, m_ipc4;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    int b;
    b = int'(a & 32'(MB - 1));
    return {mem[b], mem[(b + 1) % MB], mem[(b + 2) % MB], mem[(b + 3) % MB]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit exp_req);
    bit pop, push;
    if (rst) begin
      m_pc = RESET_PC; m_q.delete(); m_out = 0; m_drop = 0;
      m_vld = 0; m_ipc = '0; m_ins = '0; m_ipc4 = '0; m_req_pc = '0;
      return;
    end
    pop = (m_q.size() > 0) && if_ready;
    if (branch_taken) begin
      m_q.delete();
      m_pc = branch_addr & ~32'd3 & 32'(MB - 1);
      if (m_out && !imem_rvalid) m_drop = 1;
      else begin m_out = 0; m_drop = 0; end
    end else begin
      push = m_out && !m_drop && imem_rvalid;
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back({m_req_pc, imem_rdata});
      if (m_out && imem_rvalid) begin
        m_out = 0; m_drop = 0;
      end else if (exp_req && imem_ready) begin
        m_req_pc = m_pc;
        m_pc     = (m_pc + 32'd4) & 32'(MB - 1);
        m_out    = 1;
      end
    end
    m_vld = (m_q.size() > 0);
    if (m_vld) begin
      m_ipc  = m_q[0][63:32];
      m_ins  = m_q[0][31:0];
      m_ipc4 = m_ipc + 32'd4;
    end
  endtask

  // One clock cycle: drive inputs after negedge, compare, observe handshakes, advance the model.
  task automatic tick();
    bit exp_req;
    @(negedge clk);
    if (rnd) begin
      rst          = ($urandom_range(0, 199) == 0);
      imem_ready   = ($urandom_range(0, 2) != 0);
      if_ready     = ($urandom_range(0, 3) != 0);
      branch_taken = ($urandom_range(0, 11) == 0);
      branch_addr  = $urandom;
    end else begin
      rst          = d_rst;
      imem_ready   = d_ready;
      if_ready     = d_if_ready;
      branch_taken = d_br;
      branch_addr  = d_baddr;
    end
    if (rsp_pending && rsp_delay == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_at(rsp_addr);
      rsp_pending = 1'b0;
    end else begin
      if (rsp_pending) rsp_delay--;
      imem_rvalid = rnd && !rsp_pending && ($urandom_range(0, 7) == 0);
      imem_rdata  = $urandom;
    end
    #1;
    exp_req = !rst && !m_out && (m_q.size() < QD) && !branch_taken;
    if (chk_on) begin
      chk("model_imem_req", imem_req, exp_req);
      if (exp_req) chk("model_imem_addr", imem_addr, m_pc);
      chk("model_if_valid", if_valid, m_vld);
      chk("model_if_pc", if_pc, m_ipc);
      chk("model_if_instruction", if_instruction, m_ins);
      chk("model_if_pc_plus4", if_pc_plus4, m_ipc4);
    end
    if (imem_req && imem_ready) begin
      acc_log.push_back(imem_addr);
      rsp_pending = 1'b1;
      rsp_addr    = imem_addr;
      rsp_delay   = rnd ? $urandom_range(0, 3) : d_delay;
    end
    if (if_valid && if_ready) pop_log.push_back(if_pc);
    model_step(exp_req);
  endtask

  function automatic logic [31:0] q_at(input int idx, input bit from_acc);
    if (from_acc) return (acc_log.size() > idx) ? acc_log[idx] : 32'hDEAD_BEEF;
    return (pop_log.size() > idx) ? pop_log[idx] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    logic [31:0] seen_pc4;
    int          n;
    for (int i = 0; i < MB; i++) mem[i] = 8'($urandom);
    {mem[0], mem[1], mem[2], mem[3]} = 32'hE3A0_0014;
    {mem[4], mem[5], mem[6], mem[7]} = 32'hE3A0_1A01;

    rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    branch_taken = 1'b0; branch_addr = '0; if_ready = 1'b0;
    d_rst = 1'b1; d_ready = 1'b1; d_if_ready = 1'b1; d_br = 1'b0; d_baddr = '0; d_delay = 0;

    // Reset state
    tick();
    chk_on = 1'b1;
    tick();
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_instruction", if_instruction, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_pc_plus4", if_pc_plus4, 32'h0);

    // First fetches with a zero-wait memory
    d_rst = 1'b0;
    tick();
    chk("c0_imem_req", imem_req, 1'b1);
    chk("c0_imem_addr", imem_addr, 32'h0);
    tick();
    chk("c1_if_valid", if_valid, 1'b0);
    tick();
    chk("c2_if_valid", if_valid, 1'b1);
    chk("c2_if_pc", if_pc, 32'h0);
    chk("c2_if_instruction", if_instruction, 32'hE3A0_0014);
    chk("c2_if_pc_plus4", if_pc_plus4, 32'h4);
    tick();
    tick();
    chk("c4_if_valid", if_valid, 1'b1);
    chk("c4_if_pc", if_pc, 32'h4);
    chk("c4_if_pc_plus4", if_pc_plus4, 32'h8);
    chk("c4_if_instruction", if_instruction, 32'hE3A0_1A01);

    // Freeze: queue fills with 0 and 4, then issue stops
    d_rst = 1'b1; tick();
    d_rst = 1'b0; d_if_ready = 1'b0; acc_log.delete();
    repeat (10) tick();
    chk("frz_accepts", acc_log.size(), 2);
    chk("frz_acc0", q_at(0, 1), 32'h0);
    chk("frz_acc1", q_at(1, 1), 32'h4);
    chk("frz_imem_req", imem_req, 1'b0);
    chk("frz_if_pc", if_pc, 32'h0);
    chk("frz_if_valid", if_valid, 1'b1);

    // Resume: pops 0,4 in order, fetch continues at 8 (its reply held back one cycle)
    d_if_ready = 1'b1; d_delay = 1; acc_log.delete(); pop_log.delete();
    n = 0;
    while (acc_log.size() == 0 && n < 6) begin tick(); n++; end
    chk("res_accept_seen", acc_log.size(), 1);
    chk("res_pop0", q_at(0, 0), 32'h0);
    chk("res_pop1", q_at(1, 0), 32'h4);
    chk("res_acc_addr", q_at(0, 1), 32'h8);

    // Branch to 0x94 while waiting for addr 8: reply dropped
    d_delay = 0; d_br = 1'b1; d_baddr = 32'h94;
    tick();
    d_br = 1'b0;
    tick();
    chk("drop_imem_req", imem_req, 1'b0);
    chk("drop_if_valid", if_valid, 1'b0);
    tick();
    chk("br94_imem_req", imem_req, 1'b1);
    chk("br94_imem_addr", imem_addr, 32'h94);
    tick();
    tick();
    chk("br94_if_valid", if_valid, 1'b1);
    chk("br94_if_pc", if_pc, 32'h94);
    chk("br94_if_instruction", if_instruction, word_at(32'h94));

    // Branch to 0x41 in the same cycle as rvalid: no drop stall
    d_br = 1'b1; d_baddr = 32'h41;
    tick();
    d_br = 1'b0;
    tick();
    chk("br41_imem_req", imem_req, 1'b1);
    chk("br41_imem_addr", imem_addr, 32'h40);
    chk("br41_if_valid", if_valid, 1'b0);

    // Wrap at the top of memory
    d_br = 1'b1; d_baddr = 32'hFC; acc_log.delete();
    tick();
    d_br = 1'b0; seen_pc4 = '0;
    repeat (8) begin
      tick();
      if (if_valid && if_pc == 32'hFC) seen_pc4 = if_pc_plus4;
    end
    chk("wrap_acc0", q_at(0, 1), 32'hFC);
    chk("wrap_acc1", q_at(1, 1), 32'h0);
    chk("wrap_pc_plus4", seen_pc4, 32'h100);

    // Reset while waiting; the late reply lands in S_ISSUE and is ignored
    d_delay = 2; acc_log.delete();
    n = 0;
    while (acc_log.size() == 0 && n < 6) begin tick(); n++; end
    chk("rsw_accept_seen", acc_log.size(), 1);
    d_delay = 0; d_rst = 1'b1;
    tick();
    d_rst = 1'b0; d_ready = 1'b0;
    tick();
    chk("rsw_rel_if_valid", if_valid, 1'b0);
    chk("rsw_rel_imem_req", imem_req, 1'b1);
    tick();
    chk("rsw_late_if_valid", if_valid, 1'b0);
    d_ready = 1'b1; acc_log.delete();
    tick();
    chk("rsw_imem_addr", imem_addr, RESET_PC);
    chk("rsw_acc_addr", q_at(0, 1), RESET_PC);
    chk("rsw_wait_if_valid", if_valid, 1'b0);
    tick();
    chk("rsw_rsp_if_valid", if_valid, 1'b0);
    tick();
    chk("rsw_if_valid", if_valid, 1'b1);
    chk("rsw_if_pc", if_pc, RESET_PC);
    chk("rsw_if_instruction", if_instruction, 32'hE3A0_0014);

    // Random traffic against the model
    rnd = 1'b1;
    repeat (4000) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequences the byte-addressed, big-endian instruction memory for the ARM pipeline IF stage.
- Owns the fetch PC and issues word reads over a request/response handshake.
- Buffers returned words in a small prefetch queue.
- Hands instructions to ID over valid/ready.
- Handles branch redirects by flushing the queue and discarding any in-flight response.

Parameters:
RESET_PC, 0, fetch address loaded on reset (word aligned)
QUEUE_DEPTH, 2, prefetch queue entries (>=1)
MEM_BYTES, 256, instruction memory size in bytes; PC wraps modulo this (power of 2)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  read request valid
imem_addr  out  32  byte address of requested word (bits[1:0]=0)
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  instruction word {mem[a],mem[a+1],mem[a+2],mem[a+3]}
branch_taken  in  1  redirect fetch (from EXE)
branch_addr  in  32  redirect target
if_ready  in  1  ID can accept (low = freeze/hazard stall)
if_valid  out  1  queue head valid
if_instruction  out  32  queue head instruction
if_pc  out  32  address of queue head instruction
if_pc_plus4  out  32  if_pc + 4 (full 32-bit, no wrap)

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, queue empty, outstanding=0, state S_ISSUE. Outputs: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instruction=0, if_pc=0, if_pc_plus4=0.
- One outstanding request max. States:
  - S_ISSUE
  - S_WAIT (request accepted, awaiting data)
  - S_DROP (awaiting data to discard)
- S_ISSUE:
  - imem_req = (count < QUEUE_DEPTH) && !branch_taken.
  - imem_addr = pc.
  - On imem_req && imem_ready: latch req_pc=pc; pc=(pc+4) mod MEM_BYTES; go to S_WAIT.
- S_WAIT:
  - imem_req=0.
  - On imem_rvalid: push {req_pc, imem_rdata}; go to S_ISSUE.
  - imem_rvalid in S_ISSUE or before acceptance is ignored.
- S_DROP:
  - imem_req=0.
  - On imem_rvalid: discard data; go to S_ISSUE.
- Latency: response earliest one cycle after acceptance. Pushed entry is visible on if_* the cycle after push. Best case: 1 instruction per 2 cycles. With zero-wait memory, first if_valid occurs 2 cycles after rst deasserts.
- Queue:
  - FIFO order; if_* show head, driven from registers.
  - Pop on if_valid && if_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Issue is gated on count < QUEUE_DEPTH; since at most one request is outstanding, push never overflows.
  - if_ready=0 holds the head stable (freeze).
  - When empty: if_valid=0 and other if_* hold last values.
- Branch (branch_taken=1 at edge), highest priority:
  - Queue count set to 0, including an entry popped the same cycle; that handshake still counts as completed for ID.
  - pc = {branch_addr[31:2],2'b00} mod MEM_BYTES.
  - No request issued that cycle.
  - From S_WAIT without rvalid: go to S_DROP.
  - From S_WAIT with rvalid the same cycle: data discarded; go to S_ISSUE.
  - From S_DROP with rvalid: go to S_ISSUE.
  - From S_DROP without rvalid: stay in S_DROP.
  - From S_ISSUE: stay in S_ISSUE.
- Second branch while in S_DROP: pc updated again; only one response is dropped.
- Wrap: pc at MEM_BYTES-4 advances to 0.
- rst mid-operation: returns to the reset state immediately. Any response arriving afterwards is ignored, because S_ISSUE ignores rvalid.

Test Plan:
- Reset release, imem_ready=1, rvalid one cycle after each accept, memory holding MOV R0,#20 at 0 and MOV R1,#4096 at 4 -> if_valid in cycle 2; if_pc=0, if_instruction=0xE3A00014; next if_pc=4, if_pc_plus4=8.
- if_ready=0 for 10 cycles, QUEUE_DEPTH=2 -> exactly 2 accepts (addr 0,4), then imem_req=0, if_pc stays 0; on if_ready=1, pops occur in order 0,4 and fetch resumes at 8.
- branch_taken with branch_addr=0x94 while in S_WAIT for addr 8 -> queue empties, addr-8 data dropped, next imem_addr=0x94, next if_pc=0x94.
- branch_taken with branch_addr=0x41 in the same cycle as rvalid -> data dropped, next imem_addr=0x40, no S_DROP stall.
- pc=0xFC (MEM_BYTES=256), accept -> next imem_addr=0x00; if_pc_plus4 for 0xFC reads 0x100.
- Assert rst while in S_WAIT, then deliver rvalid one cycle after release -> ignored; first accepted address=RESET_PC, if_valid low until its data returns.
